// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and memory.
interface fetch_stage_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: sequential PC, one-entry skid buffer for decode stalls, and
// redirect handling that drains an outstanding memory request before refetching.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  fetch_stage_if.master    imem,
  input  logic             stall,
  input  logic             redirect,
  input  logic [15:0]      redirect_pc,
  output logic             valid,
  output logic [15:0]      instr,
  output logic [3:0]       opCode,
  output logic [15:0]      pc_out
);

  typedef enum logic [1:0] {IDLE, FETCH, FULL, DRAIN} state_t;

  state_t      state, state_next;
  logic [15:0] pc;
  logic [15:0] target;
  logic [15:0] skid_instr;
  logic [15:0] skid_pc;
  logic [15:0] redirect_tgt;

  assign redirect_tgt   = {redirect_pc[15:1], 1'b0};
  assign imem.imem_req  = (state == FETCH) || (state == DRAIN);
  // pc is frozen while draining, so the old address stays on the bus until ack
  assign imem.imem_addr = pc;
  assign opCode         = valid ? instr[15:12] : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  state_next = FETCH;
      FETCH: begin
        if (redirect)                              state_next = imem.imem_ack ? FETCH : DRAIN;
        else if (imem.imem_ack && valid && stall)  state_next = FULL;
      end
      FULL:  if (redirect || !stall) state_next = FETCH;
      DRAIN: if (imem.imem_ack)      state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      target     <= '0;
      valid      <= 1'b0;
      instr      <= '0;
      pc_out     <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else if (redirect) begin
      valid <= 1'b0;
      if (state == FETCH && !imem.imem_ack) begin
        target <= redirect_tgt;
      end else if (state == DRAIN) begin
        target <= redirect_tgt;
        if (imem.imem_ack) pc <= redirect_tgt;
      end else begin
        pc <= redirect_tgt;
      end
    end else begin
      case (state)
        FETCH: begin
          if (imem.imem_ack) begin
            pc <= pc + 16'd2;
            if (!valid || !stall) begin
              instr  <= imem.imem_rdata;
              pc_out <= pc;
              valid  <= 1'b1;
            end else begin
              skid_instr <= imem.imem_rdata;
              skid_pc    <= pc;
            end
          end else if (!stall) begin
            valid <= 1'b0;
          end
        end
        FULL: begin
          if (!stall) begin
            instr  <= skid_instr;
            pc_out <= skid_pc;
            valid  <= 1'b1;
          end
        end
        DRAIN: if (imem.imem_ack) pc <= target;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Fetch stage bench: memory responder with random latency, reference model tracking
// the in-order queue of fetched-but-unconsumed instructions.
module tb_fetch_stage;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        valid;
  logic [15:0] instr;
  logic [3:0]  opCode;
  logic [15:0] pc_out;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .imem(bus.master),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .valid(valid), .instr(instr), .opCode(opCode), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] p; logic [15:0] w; } ent_t;
  ent_t        q[$];
  bit          m_known = 0, m_idle = 1, m_drain = 0, m_fresh = 0;
  logic [15:0] m_addr = '0, m_target = '0;

  int n_tests = 0, n_fail = 0;
  int k_stall = 0, k_redir = 0, k_lat_min = 0, k_lat_max = 0, k_stray = 0, k_rst = 0;
  int f_rst = 0;
  bit f_redir = 0;
  logic [15:0] f_tgt = '0;
  bit busy = 0;
  int lat_cnt = 0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hF123;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    logic        ereq, eff_ack;
    logic [15:0] tgt;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ereq = !m_idle && (m_drain || q.size() < 2);
      if (m_known) begin
        chk("imem_req", {15'b0, bus.imem_req}, {15'b0, ereq});
        if (ereq) chk("imem_addr", bus.imem_addr, m_addr);
        chk("valid", {15'b0, valid}, {15'b0, q.size() != 0});
        if (q.size() != 0) begin
          chk("instr", instr, q[0].w);
          chk("pc_out", pc_out, q[0].p);
          chk("opCode", {12'b0, opCode}, {12'b0, q[0].w[15:12]});
        end else begin
          chk("opCode_bubble", {12'b0, opCode}, 16'h0000);
        end
        if (m_fresh) begin
          chk("reset_instr", instr, 16'h0000);
          chk("reset_pc_out", pc_out, 16'h0000);
        end
      end
      // drive stimulus for the coming edge
      if (f_rst > 0) begin rst = 1'b1; f_rst--; end
      else rst = ($urandom_range(0, 999) < k_rst * 10);
      stall = ($urandom_range(0, 99) < k_stall);
      if (f_redir) begin
        redirect = 1'b1; redirect_pc = f_tgt; f_redir = 0;
      end else begin
        redirect = ($urandom_range(0, 99) < k_redir);
        redirect_pc = ($urandom_range(0, 3) == 0) ? (16'hFFF8 | 16'($urandom_range(0, 7)))
                                                  : 16'($urandom);
      end
      if (bus.imem_req) begin
        if (!busy) begin busy = 1; lat_cnt = $urandom_range(k_lat_min, k_lat_max); end
        if (lat_cnt == 0) begin
          bus.imem_ack = 1'b1; bus.imem_rdata = mem_word(bus.imem_addr); busy = 0;
        end else begin
          lat_cnt--; bus.imem_ack = 1'b0; bus.imem_rdata = 16'($urandom);
        end
      end else begin
        busy = 0;
        bus.imem_ack = ($urandom_range(0, 99) < k_stray);
        bus.imem_rdata = 16'($urandom);
      end
      @(posedge clk);
      // reference model update from the values the DUT just sampled
      eff_ack = bus.imem_ack && ereq;
      tgt = {redirect_pc[15:1], 1'b0};
      if (rst) begin
        q.delete(); m_known = 1; m_idle = 1; m_drain = 0; m_fresh = 1; m_addr = RESET_PC;
      end else if (m_known) begin
        m_fresh = 0;
        if (m_idle) begin
          m_idle = 0;
          if (redirect) m_addr = tgt;
        end else if (redirect) begin
          q.delete();
          if (m_drain) begin
            m_target = tgt;
            if (eff_ack) begin m_drain = 0; m_addr = tgt; end
          end else if (ereq && !eff_ack) begin
            m_drain = 1; m_target = tgt;
          end else begin
            m_addr = tgt;
          end
        end else if (m_drain) begin
          if (eff_ack) begin m_drain = 0; m_addr = m_target; end
        end else begin
          if (q.size() != 0 && !stall) void'(q.pop_front());
          if (eff_ack) begin
            q.push_back('{p: m_addr, w: bus.imem_rdata});
            m_addr = m_addr + 16'd2;
          end
        end
      end
    end
  endtask

  initial begin
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    // reset, then full-rate stream with zero-latency memory
    f_rst = 2;
    cyc(14);
    // stall for three cycles, then release
    k_stall = 100; cyc(3);
    k_stall = 0;   cyc(6);
    // delayed ack with redirect to an odd address during the wait
    k_lat_min = 3; k_lat_max = 3;
    cyc(1);
    f_redir = 1; f_tgt = 16'h0041;
    cyc(10);
    // redirect coincident with ack while stalled
    k_lat_min = 0; k_lat_max = 0;
    cyc(4);
    k_stall = 100; f_redir = 1; f_tgt = 16'h0100;
    cyc(2);
    k_stall = 0; cyc(4);
    // PC wrap at the top of the address space
    f_redir = 1; f_tgt = 16'hFFFC;
    cyc(6);
    // reset while draining, with stray acks afterwards
    k_lat_min = 3; k_lat_max = 3;
    cyc(1);
    f_redir = 1; f_tgt = 16'h0200;
    cyc(1);
    f_rst = 1; k_stray = 50;
    cyc(10);
    // randomized traffic
    k_stall = 30; k_redir = 5; k_lat_min = 0; k_lat_max = 3; k_stray = 20; k_rst = 1;
    cyc(4000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 16'h0000, PC value loaded on reset; bit 0 SHALL be 0.
REQ-002 Port: clk  in  1  single clock; all state SHALL update on the rising edge only.
REQ-003 Port: rst  in  1  reset; synchronous, active-high.
REQ-004 Port: imem_req  out  1  instruction-memory request; held high until imem_ack.
REQ-005 Port: imem_addr  out  16  byte address of the requested instruction; stable while imem_req=1.
REQ-006 Port: imem_ack  in  1  one-cycle completion pulse; imem_rdata valid in the same cycle.
REQ-007 Port: imem_rdata  in  16  fetched instruction word.
REQ-008 Port: stall  in  1  decode not accepting; the output instruction SHALL be held.
REQ-009 Port: redirect  in  1  one-cycle branch/jump taken pulse.
REQ-010 Port: redirect_pc  in  16  target address; bit 0 SHALL be ignored (treated as 0).
REQ-011 Port: valid  out  1  instr/opCode/pc_out hold a live instruction.
REQ-012 Port: instr  out  16  instruction register to decode.
REQ-013 Port: opCode  out  4  instr[15:12] when valid=1, else 4'b0000 (bubble); feeds the control decoder.
REQ-014 Port: pc_out  out  16  address of instr.

Function
REQ-015 States SHALL be IDLE, FETCH, FULL, DRAIN.
REQ-016 IDLE: imem_req=0; next edge with rst=0 SHALL go to FETCH.
REQ-017 FETCH: imem_req=1, imem_addr=pc; on imem_ack, pc SHALL become pc+2 (mod 2^16, 16'hFFFE wraps to 16'h0000).
REQ-018 Ack with output register empty or consumed (valid=0 or stall=0): instr<=imem_rdata, pc_out<=old pc, valid<=1; stay in FETCH.
REQ-019 Ack with valid=1 and stall=1: word SHALL go to a one-entry skid buffer (with its pc); state->FULL.
REQ-020 FULL: imem_req=0; on stall=0, skid content SHALL move to the output register (valid=1), skid emptied, state->FETCH.
REQ-021 valid=1, stall=0, no new word this edge: valid SHALL go to 0.
REQ-022 Throughput: with imem_ack asserted in the same cycle as imem_req, one instruction per cycle; instr valid one edge after ack.
REQ-023 redirect SHALL take priority over stall and ack: valid<=0, skid emptied, pc<=redirect_pc with bit 0 cleared.
REQ-024 redirect while imem_req=1 and imem_ack=0: state->DRAIN; imem_req and imem_addr SHALL be held at the old address until ack; the returned word SHALL be discarded; then state->FETCH at the redirect pc.
REQ-025 redirect coincident with imem_ack: word discarded; state->FETCH; next imem_addr=redirect target.
REQ-026 redirect in DRAIN: stored target SHALL be replaced by the newest; drain continues.
REQ-027 redirect in FULL or IDLE: state->FETCH (IDLE->FETCH as normal).
REQ-028 Discarded or skidded words SHALL never appear on instr except via REQ-020.

Reset
REQ-029 On rst=1 at an edge: state=IDLE, pc=RESET_PC, imem_req=0, valid=0, instr=16'h0000, pc_out=16'h0000, skid empty, redirect target cleared; dominates all other inputs, including mid-DRAIN (outstanding ack after reset SHALL be ignored).

Verification
REQ-030 Reset release, ack tied to req, rdata=16'hF123 -> imem_req high one cycle after release, addr 0x0000, 0x0002...; valid=1 with opCode=4'hF, pc_out=0x0000 one edge after first ack.
REQ-031 Stream at full rate, stall=1 for 3 cycles -> instr held, one word captured in skid, imem_req low in FULL; on stall release next instr follows in order, no loss or duplicate.
REQ-032 Ack delayed 3 cycles, redirect to 16'h0041 in cycle 1 -> imem_addr holds old value until ack, word dropped, next imem_addr=16'h0040, valid=0 meanwhile, opCode=4'b0000.
REQ-033 redirect to 16'h0100 coincident with ack and stall=1 -> valid=0 next edge, skid empty, next fetch address 16'h0100.
REQ-034 PC at 16'hFFFE, ack -> next imem_addr=16'h0000.
REQ-035 rst asserted during DRAIN with late ack -> IDLE, valid=0, late word never output, fetch restarts at RESET_PC.
